// File: rtl/fifo_traffic_ctrl.sv
// Traffic generator/checker for an 8-bit single-clock FIFO: clear, counting
// burst write, idle gap, read-back compare. Option: FIFO_TRAFFIC_USEDW_CHK_EN
module fifo_traffic_ctrl #(
  parameter int DATA_W     = 8,
  parameter int USEDW_W    = 8,
  parameter int BURST_LEN  = 255,
  parameter int GAP_CYCLES = 10
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              start,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_wrreq,
  output logic              fifo_rdreq,
  output logic              fifo_sclr,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [15:0]       rd_count
`ifdef FIFO_TRAFFIC_USEDW_CHK_EN
  ,
  output logic              flag_err
`endif
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, WRITE, GAP, READ, FLUSH, DONE
  } state_t;

  localparam logic [15:0] BL16  = 16'(BURST_LEN);
  localparam logic [15:0] LAST  = 16'(BURST_LEN - 1);
  localparam logic [15:0] GLAST = 16'(GAP_CYCLES - 1);

  state_t            state;
  logic [15:0]       wr_idx;
  logic [15:0]       rd_iss;
  logic [15:0]       gap_cnt;
  logic [DATA_W-1:0] exp_data;
  logic              vld;
  logic              cmp_bad;
  logic [15:0]       err_nx;
  logic [15:0]       rd_nx;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Requests must react to this cycle's full/empty, so they stay combinational
  always_comb begin
    fifo_wrreq = (state == WRITE) && !fifo_full;
    fifo_rdreq = (state == READ) && !fifo_empty
               && (rd_iss < BL16);
    fifo_data  = (state == WRITE) ? wr_idx[DATA_W-1:0] : '0;
  end

  // Result of the compare for the byte read in the previous cycle
  always_comb begin
    cmp_bad = vld && (fifo_q != exp_data);
    err_nx  = cmp_bad ? sat_inc(err_count) : err_count;
    rd_nx   = vld ? rd_count + 16'd1 : rd_count;
  end

`ifdef FIFO_TRAFFIC_USEDW_CHK_EN
  logic gap_bad;
  logic done_bad;
  assign gap_bad  = (state == GAP) && (gap_cnt == 16'd1)
                  && (fifo_usedw != USEDW_W'(BURST_LEN));
  assign done_bad = (state == DONE)
                  && ((fifo_usedw != '0) || !fifo_empty);
`else
  logic unused_usedw;
  assign unused_usedw = ^fifo_usedw;
`endif

  // Run sequencer with registered status outputs
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state     <= IDLE;
      wr_idx    <= '0;
      rd_iss    <= '0;
      gap_cnt   <= '0;
      exp_data  <= '0;
      vld       <= 1'b0;
      fifo_sclr <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      rd_count  <= '0;
`ifdef FIFO_TRAFFIC_USEDW_CHK_EN
      flag_err  <= 1'b0;
`endif
    end else begin
      fifo_sclr <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= CLEAR;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= '0;
            rd_count  <= '0;
            fifo_sclr <= 1'b1;
`ifdef FIFO_TRAFFIC_USEDW_CHK_EN
            flag_err  <= 1'b0;
`endif
          end
        end
        CLEAR: begin
          wr_idx   <= '0;
          rd_iss   <= '0;
          gap_cnt  <= '0;
          exp_data <= '0;
          vld      <= 1'b0;
          state    <= WRITE;
        end
        WRITE: begin
          if (fifo_wrreq) begin
            wr_idx <= wr_idx + 16'd1;
            if (wr_idx == LAST) state <= GAP;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 16'd1;
          if (gap_cnt == GLAST) state <= READ;
`ifdef FIFO_TRAFFIC_USEDW_CHK_EN
          if (gap_bad) begin
            err_count <= sat_inc(err_count);
            flag_err  <= 1'b1;
          end
`endif
        end
        READ: begin
          vld <= fifo_rdreq;
          if (vld) begin
            exp_data  <= exp_data + 1'b1;
            err_count <= err_nx;
            rd_count  <= rd_nx;
          end
          if (fifo_rdreq) begin
            rd_iss <= rd_iss + 16'd1;
            if (rd_iss == LAST) state <= FLUSH;
          end
        end
        FLUSH: begin
          vld       <= 1'b0;
          if (vld) exp_data <= exp_data + 1'b1;
          err_count <= err_nx;
          rd_count  <= rd_nx;
          pass      <= (err_nx == 16'd0) && (rd_nx == BL16);
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
`ifdef FIFO_TRAFFIC_USEDW_CHK_EN
          if (done_bad) begin
            err_count <= sat_inc(err_count);
            pass      <= 1'b0;
            flag_err  <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_traffic_ctrl.md
Name: fifo_traffic_ctrl

Overview:
- Synthesizable traffic generator and checker for the 8-bit single-clock FIFO (256 deep, 8-bit usedw, sclr, almost_empty/almost_full).
- Drives the FIFO write side and consumes the read side.
- Per run: clear, write a counting burst, idle for a gap, read the burst back and compare every byte. Reports pass/fail and counts.
- Used as on-board self-test logic next to the FIFO instance.

Parameters:
- DATA_W, 8: FIFO data width.
- USEDW_W, 8: FIFO usedw width.
- BURST_LEN, 255: bytes written and read per run; legal range 1..2**USEDW_W-1.
- GAP_CYCLES, 10: idle cycles between the write phase and the read phase; legal range 1..65535.

Ports:
- clock, input, 1: system clock, rising edge.
- aclr, input, 1: asynchronous active-high reset.
- start, input, 1: one-cycle pulse that launches a run; ignored while busy.
- fifo_data, output, DATA_W: FIFO write data.
- fifo_wrreq, output, 1: FIFO write request.
- fifo_rdreq, output, 1: FIFO read request.
- fifo_sclr, output, 1: FIFO synchronous clear.
- fifo_q, input, DATA_W: FIFO read data, valid 1 cycle after an accepted rdreq.
- fifo_empty, input, 1: FIFO empty flag.
- fifo_full, input, 1: FIFO full flag.
- fifo_usedw, input, USEDW_W: FIFO occupancy (used only with the optional feature).
- busy, output, 1: high from start acceptance until DONE.
- done, output, 1: one-cycle pulse at the end of a run.
- pass, output, 1: result of the last run; held until the next start.
- err_count, output, 16: mismatches in the last run; saturates at 16'hFFFF.
- rd_count, output, 16: bytes checked in the last run.

Behaviour:
- aclr high:
  - All outputs go to 0 immediately; state goes to IDLE.
  - An in-flight run is abandoned; the next start begins a fresh run.
- States: IDLE, CLEAR, WRITE, GAP, READ, FLUSH, DONE.
- IDLE: start=1 -> CLEAR. busy=1, err_count=0, rd_count=0, pass=0.
- CLEAR: fifo_sclr=1 for exactly 1 cycle; write index reset to 0 -> WRITE.
- WRITE:
  - fifo_wrreq = !fifo_full; fifo_data = write index (low DATA_W bits).
  - The index increments only on an accepted write (wrreq & !full).
  - After BURST_LEN accepted writes -> GAP. fifo_wrreq is low in the cycle GAP is entered.
- GAP: counts GAP_CYCLES cycles with wrreq=rdreq=0 -> READ.
- READ:
  - fifo_rdreq = !fifo_empty AND reads issued < BURST_LEN.
  - An accepted read sets a 1-cycle valid pipeline flag.
  - In the following cycle fifo_q is compared with the expected counter, which starts at 0 and increments per compared byte.
  - Each compare increments rd_count. A mismatch increments err_count (saturating).
  - All BURST_LEN reads issued -> FLUSH.
- FLUSH: 1 cycle for the final compare -> DONE.
- DONE:
  - done=1 for 1 cycle.
  - pass = (err_count==0 AND rd_count==BURST_LEN), counting the final compare.
  - busy=0 -> IDLE.
- fifo_wrreq and fifo_rdreq are never high in the same cycle.
- Neither request is issued against full/empty; the FIFO's overflow/underflow checking is not relied on.
- FIFO empty during READ before BURST_LEN reads: wait indefinitely; there is no timeout.
- start pulses while busy are ignored; start in the same cycle as DONE is ignored.
- Write index and expected counter wrap mod 2**DATA_W.

Optional Feature:
- Macro: FIFO_TRAFFIC_USEDW_CHK_EN.
- When defined:
  - On the 2nd cycle of GAP, fifo_usedw must equal BURST_LEN.
  - In DONE, fifo_usedw must equal 0 and fifo_empty must be 1.
  - Each violation adds 1 to err_count and forces pass=0.
  - A 1-bit output flag_err (reset 0, cleared at start) is set on any violation.
- When undefined: these checks and the flag_err port do not exist; usedw is unused.

Test Plan:
- Reset then start, BURST_LEN=255, ideal FIFO model:
  - 255 writes with data 0..254, then GAP_CYCLES idle, then 255 reads.
  - done pulse; pass=1, err_count=0, rd_count=255.
- FIFO model corrupts the byte at read index 100 (q=8'hFF):
  - pass=0, err_count=1, rd_count=255.
- BURST_LEN=255 into a model with depth 16 that asserts full, with a drainer releasing 1 entry every 4 cycles:
  - wrreq is never high while full; the write index stalls.
  - All 255 values are still written in order.
- Hold fifo_empty=1 for 50 cycles mid-READ:
  - rdreq stays 0 and busy stays 1.
  - The run resumes and completes with pass=1.
- Assert aclr mid-WRITE at index 37:
  - All outputs are 0 asynchronously.
  - A new start gives sclr, a write sequence restarting at 0, and pass=1.
- With FIFO_TRAFFIC_USEDW_CHK_EN, model reports usedw=254 during GAP:
  - flag_err=1, pass=0, err_count=1.
